// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake, flush and a 2-entry skid buffer.
// Define PIPE_STAT_EN to add saturating stall/bubble counters; otherwise those outputs are tied to 0.
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   // Handshake: a bundle moves on an edge where valid && ready are both high on that side;
   // out_data is held stable while out_valid=1 and out_ready=0; in_ready comes only from a flop.

   // {skid_v, main_v}; 2'b10 is unreachable.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FULL  = 2'b01,
      SKID  = 2'b11
   } state_e;

   // Flush clears the control bits and keeps the rest of the bundle.
   localparam logic [DATA_W-1:0] KEEP_MASK = {DATA_W{1'b1}} << CTRL_W;

   state_e            state;
   state_e            state_nxt;
   logic [DATA_W-1:0] main_data;
   logic [DATA_W-1:0] main_nxt;
   logic [DATA_W-1:0] skid_data;
   logic [DATA_W-1:0] skid_nxt;
   logic              accept;
   logic              drain;

   assign in_ready  = ~state[1];
   assign out_valid = state[0];
   assign out_data  = main_data;
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         main_data <= '0;
         skid_data <= '0;
      end else begin
         state     <= state_nxt;
         main_data <= main_nxt;
         skid_data <= skid_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      main_nxt  = main_data;
      skid_nxt  = skid_data;
      if (flush) begin
         state_nxt = EMPTY;
         main_nxt  = main_data & KEEP_MASK;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state_nxt = FULL;
                  main_nxt  = in_data;
               end
            end
            FULL: begin
               if (accept && drain) begin
                  main_nxt = in_data;
               end else if (accept) begin
                  state_nxt = SKID;
                  skid_nxt  = in_data;
               end else if (drain) begin
                  state_nxt = EMPTY;
               end
            end
            SKID: begin
               if (drain) begin
                  state_nxt = FULL;
                  main_nxt  = skid_data;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

`ifdef PIPE_STAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (!out_valid && (bubble_cnt != {CNT_W{1'b1}}))
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (DATA_W=32, CTRL_W=8, CNT_W=4).
// Counter saturation/flush/reset checks run when PIPE_STAT_EN is defined; otherwise counters must read 0.
module tb_pipe_stage_reg;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 8;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  bubble_cnt;

   logic [DATA_W-1:0] exp_q[$];
   int                n_checks = 0;
   int                n_fail   = 0;
   logic              accepted;

   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
   );

   // clock / reset
   always #5 clk = ~clk;

   // advance one edge and sample 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive_idle();
      in_valid  = 1'b0;
      in_data   = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      tick();
      tick();
      rst = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_data", out_data, 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);

      // streaming 1..4 at full throughput
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_data = 32'(i);
         tick();
         check("stream_valid", 32'(out_valid), 32'd1);
         check("stream_data", out_data, 32'(i));
         check("stream_ready", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b0;
      tick();
      check("stream_drained", 32'(out_valid), 32'd0);

      // backpressure: A accepted with ready high, then out_ready drops
      exp_q = '{32'hA, 32'hB, 32'hC};
      in_valid  = 1'b1;
      in_data   = 32'hA;
      out_ready = 1'b1;
      tick();
      in_data   = 32'hB;
      out_ready = 1'b0;
      tick();
      check("bp_skid_ready", 32'(in_ready), 32'd0);
      check("bp_hold_data", out_data, 32'hA);
      in_data = 32'hC;
      tick();
      check("bp_still_full", 32'(in_ready), 32'd0);
      check("bp_stable_data", out_data, 32'hA);
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 12 && exp_q.size() > 0; cyc++) begin
         if (out_valid && out_ready)
            check("bp_order", out_data, exp_q.pop_front());
         accepted = in_valid && in_ready;
         tick();
         if (accepted)
            in_valid = 1'b0;
      end
      check("bp_leftover", 32'(exp_q.size()), 32'd0);
      in_valid = 1'b0;
      tick();
      check("bp_no_dup", 32'(out_valid), 32'd0);

      // flush while in SKID with a simultaneous in_valid
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h123456FF;
      tick();
      in_data = 32'h11111111;
      tick();
      check("fl_skid_full", 32'(in_ready), 32'd0);
      flush   = 1'b1;
      in_data = 32'h22222222;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl_out_valid", 32'(out_valid), 32'd0);
      check("fl_in_ready", 32'(in_ready), 32'd1);
      check("fl_out_data", out_data, 32'h12345600);
      in_valid  = 1'b1;
      in_data   = 32'h33;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("fl_next_valid", 32'(out_valid), 32'd1);
      check("fl_next_data", out_data, 32'h33);
      tick();
      check("fl_next_gone", 32'(out_valid), 32'd0);

      // reset while in SKID with in_valid high
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hAA;
      tick();
      in_data = 32'hBB;
      tick();
      in_data = 32'hCC;
      rst     = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_out_data", out_data, 32'd0);
      check("mrst_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("mrst_no_output", 32'(out_valid), 32'd0);

      // flush and drain on the same edge
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h5A5A5AC3;
      tick();
      in_valid = 1'b0;
      flush    = 1'b1;
      check("fd_sampled_valid", 32'(out_valid), 32'd1);
      check("fd_sampled_data", out_data, 32'h5A5A5AC3);
      tick();
      flush = 1'b0;
      check("fd_empty", 32'(out_valid), 32'd0);
      check("fd_ctrl_zeroed", out_data, 32'h5A5A5A00);
      check("fd_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("fd_no_dup", 32'(out_valid), 32'd0);

`ifdef PIPE_STAT_EN
      rst = 1'b1;
      drive_idle();
      tick();
      rst = 1'b0;
      check("cnt_rst_stall", 32'(stall_cnt), 32'd0);
      check("cnt_rst_bubble", 32'(bubble_cnt), 32'd0);
      in_valid = 1'b1;
      in_data  = 32'h77;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++)
         tick();
      check("cnt_stall_sat", 32'(stall_cnt), 32'd15);
      check("cnt_bubble_one", 32'(bubble_cnt), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      check("cnt_flush_stall", 32'(stall_cnt), 32'd15);
      check("cnt_flush_bubble", 32'(bubble_cnt), 32'd2);
      tick();
      tick();
      tick();
      check("cnt_bubble_run", 32'(bubble_cnt), 32'd5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("cnt_clr_stall", 32'(stall_cnt), 32'd0);
      check("cnt_clr_bubble", 32'(bubble_cnt), 32'd0);
`else
      check("cnt_off_stall", 32'(stall_cnt), 32'd0);
      check("cnt_off_bubble", 32'(bubble_cnt), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
